// File: rtl/dev_bus_arbiter.sv
// Two-master arbiter for the timer device bus: request/grant/ack FSM, address decode, read mux and HWInt register.
// Define DEV_BUS_ARB_FIXED_PRIO_EN for fixed M0 priority; otherwise arbitration is round-robin.
module dev_bus_arbiter #(
  parameter logic [31:0] DEV0_BASE = 32'h0000_7F00,
  parameter logic [31:0] DEV1_BASE = 32'h0000_7F10,
  parameter int          DEV_WORDS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wd,
  output logic        m0_ack,
  output logic        m0_err,
  output logic [31:0] m0_rd,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wd,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] m1_rd,
  output logic [31:0] DEV_Addr,
  output logic [31:0] DEV_WD,
  output logic        DEV0_WE,
  output logic        DEV1_WE,
  input  logic [31:0] DEV0_RD,
  input  logic [31:0] DEV1_RD,
  input  logic        intrp0,
  input  logic        intrp1,
  output logic [5:0]  HWInt
);

  localparam logic [31:0] DEV0_LAST = DEV0_BASE + 32'(4 * DEV_WORDS - 1);
  localparam logic [31:0] DEV1_LAST = DEV1_BASE + 32'(4 * DEV_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic        r_grant;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wd;

  logic        r_m0Ack;
  logic        r_m0Err;
  logic [31:0] r_m0Rd;
  logic        r_m1Ack;
  logic        r_m1Err;
  logic [31:0] r_m1Rd;
  logic [5:0]  r_hwInt;

  logic        w_anyReq;
  logic        w_pick;
  logic        w_hit0;
  logic        w_hit1;
  logic        w_aligned;
  logic        w_ok;
  logic        w_err;
  logic [31:0] w_rdData;
  logic        w_respond;

`ifdef DEV_BUS_ARB_FIXED_PRIO_EN
  always_comb begin
    w_pick = ~m0_req;
  end
`else
  logic r_lastGrant;

  // w_pick: 0 selects M0, 1 selects M1; contention goes to the master not served last
  always_comb begin
    w_pick = 1'b0;
    if (m0_req && m1_req) begin
      w_pick = ~r_lastGrant;
    end else if (m1_req) begin
      w_pick = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_lastGrant <= 1'b1;
    end else if (r_state == S_IDLE && w_anyReq) begin
      r_lastGrant <= w_pick;
    end
  end
`endif

  assign w_anyReq = m0_req | m1_req;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (w_anyReq) w_nextState = S_ACCESS;
      S_ACCESS: w_nextState = S_RESP;
      S_RESP:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // Winner's request is captured once so the bus stays stable through ACCESS and RESP
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_grant <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wd    <= 32'h0;
    end else if (r_state == S_IDLE && w_anyReq) begin
      r_grant <= w_pick;
      r_we    <= w_pick ? m1_we   : m0_we;
      r_addr  <= w_pick ? m1_addr : m0_addr;
      r_wd    <= w_pick ? m1_wd   : m0_wd;
    end
  end

  assign w_hit0    = (r_addr >= DEV0_BASE) && (r_addr <= DEV0_LAST);
  assign w_hit1    = (r_addr >= DEV1_BASE) && (r_addr <= DEV1_LAST);
  assign w_aligned = (r_addr[1:0] == 2'b00);
  assign w_ok      = (w_hit0 | w_hit1) & w_aligned;
  assign w_err     = ~w_ok;
  assign w_respond = (r_state == S_ACCESS);

  always_comb begin
    w_rdData = 32'h0;
    if (!r_we && w_ok) begin
      w_rdData = w_hit0 ? DEV0_RD : DEV1_RD;
    end
  end

  assign DEV_Addr = r_addr;
  assign DEV_WD   = r_wd;
  assign DEV0_WE  = w_respond && r_we && w_hit0 && w_aligned;
  assign DEV1_WE  = w_respond && r_we && w_hit1 && w_aligned;

  // Responses are registered at the ACCESS->RESP edge; rd/err hold until that master's next ack
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_m0Ack <= 1'b0;
      r_m0Err <= 1'b0;
      r_m0Rd  <= 32'h0;
      r_m1Ack <= 1'b0;
      r_m1Err <= 1'b0;
      r_m1Rd  <= 32'h0;
    end else begin
      r_m0Ack <= w_respond && !r_grant;
      r_m1Ack <= w_respond && r_grant;
      if (w_respond && !r_grant) begin
        r_m0Err <= w_err;
        r_m0Rd  <= w_rdData;
      end
      if (w_respond && r_grant) begin
        r_m1Err <= w_err;
        r_m1Rd  <= w_rdData;
      end
    end
  end

  assign m0_ack = r_m0Ack;
  assign m0_err = r_m0Err;
  assign m0_rd  = r_m0Rd;
  assign m1_ack = r_m1Ack;
  assign m1_err = r_m1Err;
  assign m1_rd  = r_m1Rd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hwInt <= 6'b0;
    end else begin
      r_hwInt <= {4'b0000, intrp1, intrp0};
    end
  end

  assign HWInt = r_hwInt;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// Self-checking bench for dev_bus_arbiter: table-driven single accesses plus reset-abort,
// contention and interrupt sequences.
module tb_dev_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_we, m0_ack, m0_err;
  logic [31:0] m0_addr, m0_wd, m0_rd;
  logic        m1_req, m1_we, m1_ack, m1_err;
  logic [31:0] m1_addr, m1_wd, m1_rd;
  logic [31:0] DEV_Addr, DEV_WD, DEV0_RD, DEV1_RD;
  logic        DEV0_WE, DEV1_WE;
  logic        intrp0, intrp1;
  logic [5:0]  HWInt;

  int nCompared;
  int nMismatched;

  typedef struct {
    logic        master;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        expWe0;
    logic        expWe1;
    logic        expErr;
    logic [31:0] expRd;
  } vec_t;

  vec_t vecs[10];

  dev_bus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wd(m0_wd),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rd(m0_rd),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wd(m1_wd),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rd(m1_rd),
    .DEV_Addr(DEV_Addr), .DEV_WD(DEV_WD),
    .DEV0_WE(DEV0_WE), .DEV1_WE(DEV1_WE),
    .DEV0_RD(DEV0_RD), .DEV1_RD(DEV1_RD),
    .intrp0(intrp0), .intrp1(intrp1), .HWInt(HWInt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One complete access, started at a negedge while the FSM is in IDLE
  task automatic applyStimulus(input vec_t v, input string tag);
    DEV0_RD = v.d0;
    DEV1_RD = v.d1;
    if (v.master) begin
      m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wd = v.wd;
    end else begin
      m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wd = v.wd;
    end
    nextCycle();
    checkOutput({tag, ".we0"}, 32'(DEV0_WE), 32'(v.expWe0));
    checkOutput({tag, ".we1"}, 32'(DEV1_WE), 32'(v.expWe1));
    checkOutput({tag, ".addr"}, DEV_Addr, v.addr);
    checkOutput({tag, ".wd"}, DEV_WD, v.wd);
    checkOutput({tag, ".ackEarly"}, 32'({m1_ack, m0_ack}), 32'(0));
    nextCycle();
    checkOutput({tag, ".ack"}, 32'({m1_ack, m0_ack}), v.master ? 32'(2) : 32'(1));
    checkOutput({tag, ".err"}, 32'(v.master ? m1_err : m0_err), 32'(v.expErr));
    checkOutput({tag, ".rd"}, v.master ? m1_rd : m0_rd, v.expRd);
    checkOutput({tag, ".weResp"}, 32'({DEV1_WE, DEV0_WE}), 32'(0));
    m0_req = 1'b0;
    m1_req = 1'b0;
    nextCycle();
    checkOutput({tag, ".ackIdle"}, 32'({m1_ack, m0_ack}), 32'(0));
  endtask

  initial begin
    nCompared = 0;
    nMismatched = 0;
    reset = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wd = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wd = 0;
    DEV0_RD = 0; DEV1_RD = 0; intrp0 = 0; intrp1 = 0;

    //          master we  addr           wd            d0            d1            we0 we1 err rd
    vecs[0] = '{1'b0, 1'b1, 32'h0000_7F04, 32'h0000_0007, 32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_7F10, 32'h0,        32'h0,        32'h0000_1234, 1'b0, 1'b0, 1'b0, 32'h0000_1234};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_7F0C, 32'h0000_0005, 32'h0000_9999, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_7F02, 32'h0000_0006, 32'h0000_9999, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_7F18, 32'h0000_00AB, 32'h0,        32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_7F08, 32'h0,        32'h0000_CAFE, 32'h0000_BEEF, 1'b0, 1'b0, 1'b0, 32'h0000_CAFE};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_7F1C, 32'h0,        32'h0,        32'h0000_0055, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 1'b0, 32'h0000_7EFC, 32'h0,        32'h0000_0077, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    vecs[8] = '{1'b1, 1'b1, 32'h0000_7F1A, 32'h0000_0001, 32'h0,        32'h0,        1'b0, 1'b0, 1'b1, 32'h0};
    vecs[9] = '{1'b0, 1'b0, 32'h0000_7F00, 32'h0,        32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0, 1'b0, 32'h0000_0011};

    @(negedge clk);
    doReset();
    checkOutput("rst.addr", DEV_Addr, 32'h0);
    checkOutput("rst.wd", DEV_WD, 32'h0);
    checkOutput("rst.acks", 32'({m1_ack, m0_ack, m1_err, m0_err}), 32'(0));
    checkOutput("rst.we", 32'({DEV1_WE, DEV0_WE}), 32'(0));
    checkOutput("rst.m0rd", m0_rd, 32'h0);
    checkOutput("rst.m1rd", m1_rd, 32'h0);
    checkOutput("rst.hwint", 32'(HWInt), 32'(0));

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted during the ACCESS cycle aborts the write
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_7F04; m0_wd = 32'h0000_0009;
    nextCycle();
    checkOutput("abort.weBefore", 32'(DEV0_WE), 32'(1));
    reset = 1'b0;
    nextCycle();
    checkOutput("abort.weAfter", 32'(DEV0_WE), 32'(0));
    checkOutput("abort.noAck", 32'({m1_ack, m0_ack}), 32'(0));
    checkOutput("abort.addrClr", DEV_Addr, 32'h0);
    reset = 1'b1;
    nextCycle();
    checkOutput("abort.retryAccess", 32'({m0_ack, DEV0_WE}), 32'(1));
    checkOutput("abort.retryAddr", DEV_Addr, 32'h0000_7F04);
    nextCycle();
    checkOutput("abort.retryAck", 32'({m1_ack, m0_ack}), 32'(1));
    checkOutput("abort.retryErr", 32'(m0_err), 32'(0));
    m0_req = 1'b0;
    nextCycle();

    // Continuous contention: four accesses, one every three cycles
    doReset();
    DEV0_RD = 32'h0000_AAAA; DEV1_RD = 32'h0000_BBBB;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_7F00; m0_wd = 32'h0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_7F14; m1_wd = 32'h0;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] expAck;
`ifdef DEV_BUS_ARB_FIXED_PRIO_EN
      expAck = 2'b01;
`else
      expAck = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      nextCycle();
      checkOutput($sformatf("cont%0d.ackEarly", k), 32'({m1_ack, m0_ack}), 32'(0));
      nextCycle();
      checkOutput($sformatf("cont%0d.ack", k), 32'({m1_ack, m0_ack}), 32'(expAck));
      checkOutput($sformatf("cont%0d.rd", k), expAck[1] ? m1_rd : m0_rd,
                  expAck[1] ? 32'h0000_BBBB : 32'h0000_AAAA);
      nextCycle();
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    nextCycle();

    // Interrupt vector is a one-cycle registered copy
    intrp1 = 1'b1;
    checkOutput("hw.delay", 32'(HWInt), 32'(0));
    nextCycle();
    checkOutput("hw.int1", 32'(HWInt), 32'(6'b000010));
    intrp0 = 1'b1;
    nextCycle();
    checkOutput("hw.both", 32'(HWInt), 32'(6'b000011));
    intrp0 = 1'b0;
    intrp1 = 1'b0;
    checkOutput("hw.holdDelay", 32'(HWInt), 32'(6'b000011));
    nextCycle();
    checkOutput("hw.clear", 32'(HWInt), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
